// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage: latches execute results, issues one data-memory
// access per load/store, stalls upstream until dhit, selects writeback data.
module exmem_stage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              flush_in,
    input  logic              valid_in,
    input  logic [WORD_W-1:0] alu_out_in,
    input  logic [WORD_W-1:0] rdat2_in,
    input  logic [WORD_W-1:0] pcplusfour_in,
    input  logic [REG_W-1:0]  wsel_in,
    input  logic              RegWr_in,
    input  logic              MemtoReg_in,
    input  logic              jal_s_in,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              halt_in,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              stall_out,
    output logic              valid_out,
    output logic [WORD_W-1:0] wdat_out,
    output logic [REG_W-1:0]  wsel_out,
    output logic              RegWr_out,
    output logic              halt_out,
    output logic [CNT_W-1:0]  mem_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              valid_q;
    logic [WORD_W-1:0] alu_q;
    logic [WORD_W-1:0] rdat2_q;
    logic [WORD_W-1:0] pcplus4_q;
    logic [WORD_W-1:0] load_q;
    logic [REG_W-1:0]  wsel_q;
    logic              regwr_q;
    logic              memtoreg_q;
    logic              jal_q;
    logic              dren_q;
    logic              dwen_q;
    logic              halt_q;
    logic [CNT_W-1:0]  cnt_q;

    logic advance_c;
    logic cap_valid_c;
    logic cap_mem_c;

    // A halt is captured as a real instruction but never reaches memory.
    assign advance_c   = ihit & ~stall_out & ~halt_q;
    assign cap_valid_c = valid_in & ~flush_in;
    assign cap_mem_c   = cap_valid_c & ~halt_in & (dREN_in | dWEN_in);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance decides REQ vs IDLE; dhit closes an open request.
    always_comb begin
        state_d = state_q;
        if (advance_c) begin
            state_d = cap_mem_c ? REQ : IDLE;
        end else if ((state_q == REQ) && dhit) begin
            state_d = DONE;
        end
    end

    // Pipeline latch, load capture, sticky halt and wait counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q    <= 1'b0;
            alu_q      <= '0;
            rdat2_q    <= '0;
            pcplus4_q  <= '0;
            load_q     <= '0;
            wsel_q     <= '0;
            regwr_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            jal_q      <= 1'b0;
            dren_q     <= 1'b0;
            dwen_q     <= 1'b0;
            halt_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (advance_c) begin
                if (cap_valid_c) begin
                    valid_q    <= 1'b1;
                    alu_q      <= alu_out_in;
                    rdat2_q    <= rdat2_in;
                    pcplus4_q  <= pcplusfour_in;
                    wsel_q     <= wsel_in;
                    regwr_q    <= RegWr_in;
                    memtoreg_q <= MemtoReg_in;
                    jal_q      <= jal_s_in;
                    dren_q     <= dREN_in & ~halt_in;
                    dwen_q     <= dWEN_in & ~halt_in;
                    if (halt_in) begin
                        halt_q <= 1'b1;
                    end
                end else begin
                    valid_q    <= 1'b0;
                    alu_q      <= '0;
                    rdat2_q    <= '0;
                    pcplus4_q  <= '0;
                    wsel_q     <= '0;
                    regwr_q    <= 1'b0;
                    memtoreg_q <= 1'b0;
                    jal_q      <= 1'b0;
                    dren_q     <= 1'b0;
                    dwen_q     <= 1'b0;
                end
            end
            if ((state_q == REQ) && dhit && dren_q) begin
                load_q <= dmemload;
            end
            if ((state_q == REQ) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_out    = (state_q == REQ);
    assign dmemREN      = (state_q == REQ) & dren_q;
    assign dmemWEN      = (state_q == REQ) & dwen_q;
    assign dmemaddr     = alu_q;
    assign dmemstore    = rdat2_q;
    assign valid_out    = valid_q & (state_q != REQ);
    assign RegWr_out    = regwr_q & valid_out;
    assign wsel_out     = wsel_q;
    assign wdat_out     = memtoreg_q ? load_q : (jal_q ? pcplus4_q : alu_q);
    assign halt_out     = halt_q;
    assign mem_wait_cnt = cnt_q;

endmodule

// File: tb/tb_exmem_stage.sv
// Scoreboarded bench for exmem_stage: stimulus pushes expected writebacks,
// a negedge monitor pops them whenever a freshly captured instruction
// presents valid_out; request/stall/halt behaviour is checked inline.
module tb_exmem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, flush_in, valid_in;
    logic [31:0] alu_out_in, rdat2_in, pcplusfour_in, dmemload;
    logic [4:0]  wsel_in;
    logic        RegWr_in, MemtoReg_in, jal_s_in, dREN_in, dWEN_in, halt_in;
    logic        dmemREN, dmemWEN, stall_out, valid_out, RegWr_out, halt_out;
    logic [31:0] dmemaddr, dmemstore, wdat_out;
    logic [4:0]  wsel_out;
    logic [15:0] mem_wait_cnt;

    typedef struct {
        logic [31:0] wdat;
        logic [4:0]  wsel;
        logic        regwr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    exmem_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .flush_in(flush_in),
        .valid_in(valid_in), .alu_out_in(alu_out_in), .rdat2_in(rdat2_in),
        .pcplusfour_in(pcplusfour_in), .wsel_in(wsel_in), .RegWr_in(RegWr_in),
        .MemtoReg_in(MemtoReg_in), .jal_s_in(jal_s_in), .dREN_in(dREN_in),
        .dWEN_in(dWEN_in), .halt_in(halt_in), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .stall_out(stall_out), .valid_out(valid_out),
        .wdat_out(wdat_out), .wsel_out(wsel_out), .RegWr_out(RegWr_out),
        .halt_out(halt_out), .mem_wait_cnt(mem_wait_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_in();
        ihit = 1'b0; flush_in = 1'b0; valid_in = 1'b0;
        alu_out_in = '0; rdat2_in = '0; pcplusfour_in = '0; wsel_in = '0;
        RegWr_in = 1'b0; MemtoReg_in = 1'b0; jal_s_in = 1'b0;
        dREN_in = 1'b0; dWEN_in = 1'b0; halt_in = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] w, input logic [4:0] s, input logic r);
        exp_t e;
        e.wdat = w; e.wsel = s; e.regwr = r;
        exp_q.push_back(e);
    endtask

    // Advance one edge, then release the instruction inputs.
    task automatic edge_clr();
        @(posedge CLK); #1;
        clr_in();
    endtask

    // Monitor: compare writeback of each newly captured instruction once it presents.
    initial begin
        logic pend;
        logic fresh;
        exp_t e;
        pend = 1'b0;
        fresh = 1'b0;
        forever begin
            @(negedge CLK);
            if (pend) fresh = 1'b1;
            if (fresh && valid_out === 1'b1) begin
                fresh = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'(valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_wdat", wdat_out, e.wdat);
                    chk("sb_wsel", 32'(wsel_out), 32'(e.wsel));
                    chk("sb_regwr", 32'(RegWr_out), 32'(e.regwr));
                end
            end
            pend = ihit & ~stall_out & ~halt_out & ~RST;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr_in();
        dhit = 1'b0; dmemload = '0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_ren", 32'(dmemREN), 32'd0);
        chk("rst_wen", 32'(dmemWEN), 32'd0);
        chk("rst_halt", 32'(halt_out), 32'd0);
        chk("rst_cnt", 32'(mem_wait_cnt), 32'd0);
        chk("rst_wdat", wdat_out, 32'd0);

        // ALU op
        @(posedge CLK); #1;
        valid_in = 1; alu_out_in = 32'h10; wsel_in = 5'd3; RegWr_in = 1; ihit = 1;
        push_exp(32'h10, 5'd3, 1'b1);
        edge_clr();
        @(negedge CLK);
        chk("alu_stall", 32'(stall_out), 32'd0);
        chk("alu_ren", 32'(dmemREN), 32'd0);
        chk("alu_wen", 32'(dmemWEN), 32'd0);

        // Load, dhit on the 3rd REQ cycle
        @(posedge CLK); #1;
        valid_in = 1; dREN_in = 1; alu_out_in = 32'h100; MemtoReg_in = 1;
        wsel_in = 5'd5; RegWr_in = 1; ihit = 1;
        push_exp(32'hDEADBEEF, 5'd5, 1'b1);
        edge_clr();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("ld_stall", 32'(stall_out), 32'd1);
            chk("ld_ren", 32'(dmemREN), 32'd1);
            chk("ld_addr", dmemaddr, 32'h100);
            chk("ld_valid_hidden", 32'(valid_out), 32'd0);
            if (i == 2) begin
                dhit = 1; dmemload = 32'hDEADBEEF;
            end
        end
        @(posedge CLK); #1;
        dhit = 0; dmemload = '0;
        @(negedge CLK);
        chk("ld_done_stall", 32'(stall_out), 32'd0);
        chk("ld_done_ren", 32'(dmemREN), 32'd0);
        chk("ld_cnt", 32'(mem_wait_cnt), 32'd3);

        // Store, dhit after 1 cycle
        @(posedge CLK); #1;
        valid_in = 1; dWEN_in = 1; rdat2_in = 32'hCAFEF00D; alu_out_in = 32'h200; ihit = 1;
        push_exp(32'h200, 5'd0, 1'b0);
        edge_clr();
        dhit = 1;
        @(negedge CLK);
        chk("st_wen", 32'(dmemWEN), 32'd1);
        chk("st_ren", 32'(dmemREN), 32'd0);
        chk("st_data", dmemstore, 32'hCAFEF00D);
        chk("st_addr", dmemaddr, 32'h200);
        @(posedge CLK); #1;
        dhit = 0;
        @(negedge CLK);
        chk("st_wen_drop", 32'(dmemWEN), 32'd0);
        chk("st_stall_drop", 32'(stall_out), 32'd0);
        chk("st_cnt", 32'(mem_wait_cnt), 32'd4);

        // dhit and ihit coincident in REQ
        @(posedge CLK); #1;
        valid_in = 1; dREN_in = 1; alu_out_in = 32'h300; MemtoReg_in = 1;
        wsel_in = 5'd7; RegWr_in = 1; ihit = 1;
        push_exp(32'h12345678, 5'd7, 1'b1);
        edge_clr();
        dhit = 1; dmemload = 32'h12345678;
        valid_in = 1; alu_out_in = 32'h55; wsel_in = 5'd9; RegWr_in = 1; ihit = 1;
        push_exp(32'h55, 5'd9, 1'b1);
        @(negedge CLK);
        chk("co_stall", 32'(stall_out), 32'd1);
        chk("co_ren", 32'(dmemREN), 32'd1);
        @(posedge CLK); #1;
        dhit = 0; dmemload = '0;
        @(negedge CLK);
        chk("co_done_stall", 32'(stall_out), 32'd0);
        chk("co_done_ren", 32'(dmemREN), 32'd0);
        chk("co_done_wsel", 32'(wsel_out), 32'd7);
        edge_clr();
        @(negedge CLK);
        chk("co_next_ren", 32'(dmemREN), 32'd0);
        chk("co_cnt", 32'(mem_wait_cnt), 32'd5);

        // Flush bubble, then jal
        @(posedge CLK); #1;
        valid_in = 1; flush_in = 1; RegWr_in = 1; alu_out_in = 32'h77; ihit = 1;
        edge_clr();
        @(negedge CLK);
        chk("fl_valid", 32'(valid_out), 32'd0);
        chk("fl_regwr", 32'(RegWr_out), 32'd0);
        @(posedge CLK); #1;
        valid_in = 1; jal_s_in = 1; pcplusfour_in = 32'h44; alu_out_in = 32'h99;
        wsel_in = 5'd31; RegWr_in = 1; ihit = 1;
        push_exp(32'h44, 5'd31, 1'b1);
        edge_clr();
        @(negedge CLK);
        chk("jal_valid", 32'(valid_out), 32'd1);

        // Reset mid-REQ
        @(posedge CLK); #1;
        valid_in = 1; dREN_in = 1; alu_out_in = 32'h400; ihit = 1;
        edge_clr();
        @(negedge CLK);
        chk("rq_ren", 32'(dmemREN), 32'd1);
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        @(negedge CLK);
        chk("rq_ren_drop", 32'(dmemREN), 32'd0);
        chk("rq_stall_drop", 32'(stall_out), 32'd0);
        chk("rq_cnt_clr", 32'(mem_wait_cnt), 32'd0);
        chk("rq_valid", 32'(valid_out), 32'd0);

        // Halt: sticky, blocks further capture until reset
        @(posedge CLK); #1;
        valid_in = 1; halt_in = 1; dREN_in = 1; alu_out_in = 32'h11; wsel_in = 5'd2; ihit = 1;
        push_exp(32'h11, 5'd2, 1'b0);
        edge_clr();
        @(negedge CLK);
        chk("hl_halt", 32'(halt_out), 32'd1);
        chk("hl_ren", 32'(dmemREN), 32'd0);
        chk("hl_stall", 32'(stall_out), 32'd0);
        @(posedge CLK); #1;
        valid_in = 1; alu_out_in = 32'h66; wsel_in = 5'd4; RegWr_in = 1; ihit = 1;
        repeat (2) @(posedge CLK);
        #1 clr_in();
        @(negedge CLK);
        chk("hl_sticky", 32'(halt_out), 32'd1);
        chk("hl_blocked_wsel", 32'(wsel_out), 32'd2);
        chk("hl_blocked_wdat", wdat_out, 32'h11);
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        @(negedge CLK);
        chk("hl_rst_clear", 32'(halt_out), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/exmem_stage.md
Name: exmem_stage

Overview:
- EX/MEM pipeline stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX latch and the execute ALU.
- Latches the execute results and control, then drives the single data-memory request until dhit.
- Selects writeback data for the MEM/WB latch.
- Asserts stall_out to freeze upstream stages while a load/store is outstanding.

Parameters:
WORD_W, 32, datapath/word width (word_t)
REG_W, 5, register-select width
CNT_W, 16, width of saturating memory-wait cycle counter

Ports:
CLK  in  1  clock
RST  in  1  reset
ihit  in  1  global pipeline advance qualifier (icache hit)
dhit  in  1  data-memory access complete
flush_in  in  1  load bubble instead of instruction on advance
valid_in  in  1  incoming instruction is real
alu_out_in  in  WORD_W  ALU result / effective address
rdat2_in  in  WORD_W  store data
pcplusfour_in  in  WORD_W  link value for jal
wsel_in  in  REG_W  destination register
RegWr_in, MemtoReg_in, jal_s_in, dREN_in, dWEN_in, halt_in  in  1 each  control from ID/EX
dmemload  in  WORD_W  load data from memory
dmemREN  out  1  data read request
dmemWEN  out  1  data write request
dmemaddr  out  WORD_W  data address
dmemstore  out  WORD_W  store data
stall_out  out  1  freeze IF/ID/EX and ID/EX latches
valid_out  out  1  MEM/WB-bound instruction valid and complete
wdat_out  out  WORD_W  writeback data
wsel_out  out  REG_W  writeback register
RegWr_out  out  1  register write enable (gated by valid_out)
halt_out  out  1  sticky halt
mem_wait_cnt  out  CNT_W  cycles spent in REQ, saturating

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- Reset: all latched fields 0, state IDLE, halt_out 0, mem_wait_cnt 0. Every output is 0 after the reset edge. A reset mid-REQ drops dmemREN/dmemWEN on the next edge with no completion.
- advance = ihit & ~stall_out & ~halt_out.
- On advance:
  - flush_in=1 or valid_in=0: capture a bubble (valid=0, all controls 0).
  - Otherwise: capture all *_in fields.
- No advance: hold all latched fields.
- FSM states: IDLE, REQ, DONE.
  - Any state -> REQ on an advance capturing a valid instruction with dREN_in|dWEN_in.
  - Any state -> IDLE on an advance capturing a non-memory instruction or a bubble.
  - REQ -> DONE on dhit. In the same edge, load_q <= dmemload (reads only).
  - DONE holds until the next advance.
- dhit outside REQ is ignored.
- Request outputs:
  - dmemREN = (state==REQ) & dREN_q.
  - dmemWEN = (state==REQ) & dWEN_q.
  - dmemaddr = alu_q; dmemstore = rdat2_q (both valid whenever a request is asserted).
  - A request is never held past the dhit edge, and each access is issued exactly once.
- stall_out = (state==REQ), combinational.
  - dhit and ihit in the same REQ cycle: no advance (stall still 1). Advance occurs on the next ihit.
- Writeback:
  - wdat_out = MemtoReg_q ? load_q : jal_q ? pcplus4_q : alu_q.
  - valid_out = valid_q & (state!=REQ).
  - RegWr_out = RegWr_q & valid_out.
  - wsel_out = wsel_q.
- Halt: an advance capturing valid halt_in sets halt_out=1. halt_out is sticky until RST; further advances are blocked while it is set. A halt never issues a memory request.
- mem_wait_cnt: +1 each cycle in REQ, saturates at 2^CNT_W-1, cleared only by RST.

Test Plan:
- ALU op: valid_in=1, alu_out_in=0x00000010, wsel_in=3, RegWr_in=1, ihit=1 -> next cycle valid_out=1, wdat_out=0x10, wsel_out=3, stall_out=0, no dmem request.
- Load with 3-cycle latency: dREN_in=1, alu_out_in=0x100, MemtoReg_in=1. dhit on the 3rd REQ cycle with dmemload=0xDEADBEEF -> stall_out=1 for 3 cycles, dmemREN=1 at addr 0x100 for exactly those 3 cycles, then wdat_out=0xDEADBEEF, valid_out=1, mem_wait_cnt=3.
- Store: dWEN_in=1, rdat2_in=0xCAFEF00D, alu_out_in=0x200. dhit after 1 cycle -> dmemWEN=1 for 1 cycle, dmemstore=0xCAFEF00D, RegWr_out=0.
- dhit and ihit coincident in REQ -> no capture that edge, DONE next cycle; next instruction captured on the following ihit; dmemREN not re-asserted.
- flush_in=1 with ihit -> valid_out=0, RegWr_out=0. jal: jal_s_in=1, pcplusfour_in=0x44 -> wdat_out=0x44.
- RST asserted mid-REQ -> dmemREN=0 and stall_out=0 after that edge. halt_in captured -> halt_out=1 persists, later ihit captures nothing until RST.
